// File: rtl/decode_issue_ctrl.sv
// Fetch-to-decode sequencer: buffers fetched instructions, tags each with a major ID, issues under issue-queue credits, sequences decoder flushes.
// Latency: an instruction accepted at edge N is presented to the decoder after edge N+1 (empty FIFO, no stall, credits available).
// Backpressure: fetchReady_o drops on a full FIFO or during flush; stall_i freezes the decoder register; zero credits hold instructions in the FIFO.
module decode_issue_ctrl #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int fifoDepth               = 4,
  parameter int numCredits              = 8,
  parameter int decodeLatency           = 3
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               fetchValid_i,
  output logic                               fetchReady_o,
  input  logic [instructionWidth-1:0]        fetchInstruction_i,
  input  logic [addressWidth-1:0]            fetchAddress_i,
  input  logic                               fetchIs64Bit_i,
  input  logic [PidSize-1:0]                 fetchPid_i,
  input  logic [TidSize-1:0]                 fetchTid_i,
  input  logic                               stall_i,
  input  logic                               creditReturn_i,
  input  logic                               flush_i,
  output logic                               decEnable_o,
  output logic                               decStall_o,
  output logic                               decReset_o,
  output logic [instructionWidth-1:0]        decInstruction_o,
  output logic [addressWidth-1:0]            decAddress_o,
  output logic                               decIs64Bit_o,
  output logic [PidSize-1:0]                 decPid_o,
  output logic [TidSize-1:0]                 decTid_o,
  output logic [instructionCounterWidth-1:0] decMajId_o,
  output logic [$clog2(numCredits+1)-1:0]    credits_o
);

  localparam int PtrW   = (fifoDepth > 1) ? $clog2(fifoDepth) : 1;
  localparam int CntW   = $clog2(fifoDepth + 1);
  localparam int CredW  = $clog2(numCredits + 1);
  localparam int DrainW = $clog2(decodeLatency + 1);

  typedef struct packed {
    logic [instructionWidth-1:0] instr;
    logic [addressWidth-1:0]     addr;
    logic                        is64;
    logic [PidSize-1:0]          pid;
    logic [TidSize-1:0]          tid;
  } entry_t;

  typedef enum logic {RUN, FLUSH} state_t;

  entry_t                             mem [fifoDepth];
  entry_t                             dec_q;
  logic [PtrW-1:0]                    wr_ptr;
  logic [PtrW-1:0]                    rd_ptr;
  logic [CntW-1:0]                    count;
  logic [CredW-1:0]                   credits;
  logic [DrainW-1:0]                  drain;
  logic [instructionCounterWidth-1:0] maj_cnt;
  state_t                             state;
  logic                               wr_en;
  logic                               issue;

  // Ready depends only on registered state so fetch never sees a combinational path from stall/credits.
  assign fetchReady_o = (state == RUN) && (count < CntW'(fifoDepth));
  assign wr_en        = fetchValid_i && fetchReady_o && !flush_i;
  assign issue        = (state == RUN) && !flush_i && !stall_i && (count != '0) && (credits != '0);

  assign decStall_o       = stall_i;
  assign decInstruction_o = dec_q.instr;
  assign decAddress_o     = dec_q.addr;
  assign decIs64Bit_o     = dec_q.is64;
  assign decPid_o         = dec_q.pid;
  assign decTid_o         = dec_q.tid;
  assign credits_o        = credits;

  // FIFO storage: plain data, no reset needed since count gates every read.
  always_ff @(posedge clock_i) begin
    if (reset_i && wr_en) begin
      mem[wr_ptr] <= '{instr: fetchInstruction_i, addr: fetchAddress_i, is64: fetchIs64Bit_i,
                       pid: fetchPid_i, tid: fetchTid_i};
    end
  end

  // Sequencer: RUN/FLUSH FSM, FIFO pointers, credits, major ID counter and decoder output register.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state       <= RUN;
      drain       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      credits     <= CredW'(numCredits);
      maj_cnt     <= '0;
      dec_q       <= '0;
      decMajId_o  <= '0;
      decEnable_o <= 1'b0;
      decReset_o  <= 1'b1;
    end else if (flush_i) begin
      // Flush wins over stall and restarts the drain count even when already flushing.
      state       <= FLUSH;
      drain       <= DrainW'(decodeLatency);
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      decEnable_o <= 1'b0;
      decReset_o  <= 1'b1;
    end else if (state == FLUSH) begin
      // Decoder is held in reset until its pipeline has drained; returned credits are
      // meaningless here because the issue queue is refilled to full on exit.
      if (drain == DrainW'(1)) begin
        state      <= RUN;
        decReset_o <= 1'b0;
        credits    <= CredW'(numCredits);
      end else begin
        drain <= drain - 1'b1;
      end
    end else begin
      decReset_o <= 1'b0;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CntW'(wr_en) - CntW'(issue);

      // A return at full credit with no issue is dropped so the count saturates.
      if (issue && !creditReturn_i) begin
        credits <= credits - 1'b1;
      end else if (!issue && creditReturn_i && (credits != CredW'(numCredits))) begin
        credits <= credits + 1'b1;
      end

      if (!stall_i) begin
        decEnable_o <= issue;
        if (issue) begin
          dec_q      <= mem[rd_ptr];
          decMajId_o <= maj_cnt;
          maj_cnt    <= maj_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl with a scoreboard of accepted fetches checked at each decoder consume.
// A second instance with a 3-bit major ID shares all inputs so major ID wrap is exercised at ID 8.
// Inputs are driven 1ns after the rising edge; the scoreboard samples on the falling edge.
`timescale 1ns/1ps
module tb_decode_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [63:0] fetch_addr;
  logic        fetch_is64;
  logic [19:0] fetch_pid;
  logic [15:0] fetch_tid;
  logic        stall;
  logic        credit_ret;
  logic        flush;

  logic        fetch_ready, dec_enable, dec_stall, dec_reset, dec_is64;
  logic [31:0] dec_instr;
  logic [63:0] dec_addr;
  logic [19:0] dec_pid;
  logic [15:0] dec_tid;
  logic [63:0] dec_maj;
  logic [3:0]  credits;

  logic        w_fetch_ready, w_dec_enable, w_dec_stall, w_dec_reset, w_dec_is64;
  logic [31:0] w_dec_instr;
  logic [63:0] w_dec_addr;
  logic [19:0] w_dec_pid;
  logic [15:0] w_dec_tid;
  logic [2:0]  w_maj;
  logic [3:0]  w_credits;

  decode_issue_ctrl dut (
    .clock_i(clk), .reset_i(rst_n),
    .fetchValid_i(fetch_valid), .fetchReady_o(fetch_ready),
    .fetchInstruction_i(fetch_instr), .fetchAddress_i(fetch_addr), .fetchIs64Bit_i(fetch_is64),
    .fetchPid_i(fetch_pid), .fetchTid_i(fetch_tid),
    .stall_i(stall), .creditReturn_i(credit_ret), .flush_i(flush),
    .decEnable_o(dec_enable), .decStall_o(dec_stall), .decReset_o(dec_reset),
    .decInstruction_o(dec_instr), .decAddress_o(dec_addr), .decIs64Bit_o(dec_is64),
    .decPid_o(dec_pid), .decTid_o(dec_tid), .decMajId_o(dec_maj), .credits_o(credits)
  );

  decode_issue_ctrl #(.instructionCounterWidth(3)) u_wrap (
    .clock_i(clk), .reset_i(rst_n),
    .fetchValid_i(fetch_valid), .fetchReady_o(w_fetch_ready),
    .fetchInstruction_i(fetch_instr), .fetchAddress_i(fetch_addr), .fetchIs64Bit_i(fetch_is64),
    .fetchPid_i(fetch_pid), .fetchTid_i(fetch_tid),
    .stall_i(stall), .creditReturn_i(credit_ret), .flush_i(flush),
    .decEnable_o(w_dec_enable), .decStall_o(w_dec_stall), .decReset_o(w_dec_reset),
    .decInstruction_o(w_dec_instr), .decAddress_o(w_dec_addr), .decIs64Bit_o(w_dec_is64),
    .decPid_o(w_dec_pid), .decTid_o(w_dec_tid), .decMajId_o(w_maj), .credits_o(w_credits)
  );

  typedef struct {
    logic [63:0] addr;
    logic [31:0] instr;
    logic        is64;
    logic [19:0] pid;
    logic [15:0] tid;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_maj = 64'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] a_of(input int i);
    return 64'(i * 4);
  endfunction

  function automatic logic [31:0] i_of(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  task automatic drive_fetch(input int i);
    fetch_valid = 1'b1;
    fetch_addr  = a_of(i);
    fetch_instr = i_of(i);
    fetch_is64  = 1'(i & 1);
    fetch_pid   = 20'(i * 3 + 1);
    fetch_tid   = 16'(i + 100);
  endtask

  // Scoreboard: pop/compare on a decoder consume, then drop on flush or push on a fetch handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dec_enable === 1'b1 && stall === 1'b0) begin
      chk("sb_issue_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_addr", dec_addr, e.addr);
        chk("sb_instr", 64'(dec_instr), 64'(e.instr));
        chk("sb_is64", 64'(dec_is64), 64'(e.is64));
        chk("sb_pid", 64'(dec_pid), 64'(e.pid));
        chk("sb_tid", 64'(dec_tid), 64'(e.tid));
        chk("sb_majid", dec_maj, exp_maj);
        chk("sb_wrap_en", 64'(w_dec_enable), 64'd1);
        chk("sb_wrap_addr", w_dec_addr, e.addr);
        chk("sb_wrap_majid", 64'(w_maj), 64'(exp_maj[2:0]));
        exp_maj = exp_maj + 64'd1;
      end
    end
    if (flush === 1'b1) begin
      sb.delete();
    end else if (rst_n === 1'b1 && fetch_valid === 1'b1 && fetch_ready === 1'b1) begin
      sb.push_back('{addr: fetch_addr, instr: fetch_instr, is64: fetch_is64,
                     pid: fetch_pid, tid: fetch_tid});
    end
  end

  initial begin
    rst_n = 1'b0; fetch_valid = 1'b0; fetch_instr = '0; fetch_addr = '0; fetch_is64 = 1'b0;
    fetch_pid = '0; fetch_tid = '0; stall = 1'b0; credit_ret = 1'b0; flush = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst_dec_enable", 64'(dec_enable), 64'd0);
    chk("rst_dec_reset", 64'(dec_reset), 64'd1);
    chk("rst_credits", 64'(credits), 64'd8);
    chk("rst_majid", dec_maj, 64'd0);
    chk("rst_dec_addr", dec_addr, 64'd0);
    chk("rst_dec_instr", 64'(dec_instr), 64'd0);
    chk("rst_wrap_reset", 64'(w_dec_reset), 64'd1);
    chk("rst_wrap_credits", 64'(w_credits), 64'd8);
    rst_n = 1'b1;
    tick();
    chk("rel_dec_reset", 64'(dec_reset), 64'd0);
    chk("rel_fetch_ready", 64'(fetch_ready), 64'd1);
    chk("rel_wrap_ready", 64'(w_fetch_ready), 64'd1);
    chk("rel_wrap_reset", 64'(w_dec_reset), 64'd0);

    // Four back-to-back fetches, addresses 0,4,8,12
    drive_fetch(0); tick();
    chk("t1_en_accept_edge", 64'(dec_enable), 64'd0);
    drive_fetch(1); tick();
    chk("t1_en0", 64'(dec_enable), 64'd1); chk("t1_maj0", dec_maj, 64'd0);
    drive_fetch(2); tick();
    chk("t1_en1", 64'(dec_enable), 64'd1); chk("t1_maj1", dec_maj, 64'd1);
    drive_fetch(3); tick();
    chk("t1_en2", 64'(dec_enable), 64'd1); chk("t1_maj2", dec_maj, 64'd2);
    fetch_valid = 1'b0; tick();
    chk("t1_en3", 64'(dec_enable), 64'd1); chk("t1_maj3", dec_maj, 64'd3);
    tick();
    chk("t1_en_done", 64'(dec_enable), 64'd0);
    chk("t1_credits", 64'(credits), 64'd4);

    // Exhaust credits: four more issue, the ninth waits for a credit
    for (int i = 4; i <= 8; i++) begin
      drive_fetch(i); tick();
    end
    chk("t2_maj7", dec_maj, 64'd7);
    chk("t2_wrap_maj7", 64'(w_maj), 64'd7);
    fetch_valid = 1'b0; tick();
    chk("t2_held_en", 64'(dec_enable), 64'd0);
    chk("t2_credits0", 64'(credits), 64'd0);
    tick();
    chk("t2_still_held", 64'(dec_enable), 64'd0);
    credit_ret = 1'b1; tick();
    chk("t2_ret_en", 64'(dec_enable), 64'd0);
    chk("t2_ret_credits", 64'(credits), 64'd1);
    credit_ret = 1'b0; tick();
    chk("t2_ninth_en", 64'(dec_enable), 64'd1);
    chk("t2_ninth_maj", dec_maj, 64'd8);
    chk("t2_wrap_maj0", 64'(w_maj), 64'd0);
    chk("t2_ninth_credits", 64'(credits), 64'd0);
    tick();
    chk("t2_after_en", 64'(dec_enable), 64'd0);

    // Fill FIFO with no credits, then one credit frees one slot
    for (int i = 9; i <= 12; i++) begin
      drive_fetch(i); tick();
    end
    fetch_valid = 1'b0;
    chk("t3_full_ready", 64'(fetch_ready), 64'd0);
    credit_ret = 1'b1; tick();
    chk("t3_ret_ready", 64'(fetch_ready), 64'd0);
    chk("t3_ret_credits", 64'(credits), 64'd1);
    credit_ret = 1'b0; tick();
    chk("t3_pop_en", 64'(dec_enable), 64'd1);
    chk("t3_pop_maj", dec_maj, 64'd9);
    chk("t3_ready_back", 64'(fetch_ready), 64'd1);
    chk("t3_credits0", 64'(credits), 64'd0);
    tick();
    chk("t3_after_en", 64'(dec_enable), 64'd0);

    // Stall for three cycles while an instruction is presented
    credit_ret = 1'b1; tick();
    chk("t4_credit_up", 64'(credits), 64'd1);
    tick();
    chk("t4_issue_en", 64'(dec_enable), 64'd1);
    chk("t4_issue_maj", dec_maj, 64'd10);
    chk("t4_issue_credits", 64'(credits), 64'd1);
    credit_ret = 1'b0; stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_stall_en", 64'(dec_enable), 64'd1);
      chk("t4_stall_addr", dec_addr, a_of(10));
      chk("t4_stall_instr", 64'(dec_instr), 64'(i_of(10)));
      chk("t4_stall_maj", dec_maj, 64'd10);
      chk("t4_stall_credits", 64'(credits), 64'd1);
      chk("t4_dec_stall", 64'(dec_stall), 64'd1);
      chk("t4_wrap_stall", 64'(w_dec_stall), 64'd1);
    end
    stall = 1'b0; #1;
    chk("t4_dec_stall_low", 64'(dec_stall), 64'd0);
    tick();
    chk("t4_resume_en", 64'(dec_enable), 64'd1);
    chk("t4_resume_maj", dec_maj, 64'd11);
    chk("t4_resume_addr", dec_addr, a_of(11));
    chk("t4_resume_credits", 64'(credits), 64'd0);
    tick();
    chk("t4_after_en", 64'(dec_enable), 64'd0);

    // Flush with three buffered entries and a simultaneous fetch handshake
    drive_fetch(13); tick();
    drive_fetch(14); tick();
    drive_fetch(15); flush = 1'b1; tick();
    chk("t5_flush_reset0", 64'(dec_reset), 64'd1);
    chk("t5_flush_en", 64'(dec_enable), 64'd0);
    chk("t5_flush_ready", 64'(fetch_ready), 64'd0);
    chk("t5_wrap_reset", 64'(w_dec_reset), 64'd1);
    flush = 1'b0; fetch_valid = 1'b0; credit_ret = 1'b1; tick();
    chk("t5_flush_reset1", 64'(dec_reset), 64'd1);
    chk("t5_ret_ignored", 64'(credits), 64'd0);
    chk("t5_ready1", 64'(fetch_ready), 64'd0);
    credit_ret = 1'b0; tick();
    chk("t5_flush_reset2", 64'(dec_reset), 64'd1);
    tick();
    chk("t5_reset_clear", 64'(dec_reset), 64'd0);
    chk("t5_ready_back", 64'(fetch_ready), 64'd1);
    chk("t5_credits_reload", 64'(credits), 64'd8);
    chk("t5_en_idle", 64'(dec_enable), 64'd0);
    drive_fetch(16); tick();
    fetch_valid = 1'b0;
    chk("t5_accept_en", 64'(dec_enable), 64'd0);
    tick();
    chk("t5_next_en", 64'(dec_enable), 64'd1);
    chk("t5_next_maj", dec_maj, 64'd12);
    chk("t5_next_addr", dec_addr, a_of(16));
    tick();
    chk("t5_fifo_empty", 64'(dec_enable), 64'd0);
    chk("t5_credits7", 64'(credits), 64'd7);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
